// File: rtl/midi_pkg.sv
// Shared MIDI constants, message classes and scheduler FSM states.
package midi_pkg;

  // Status nibbles (upper four bits of the status byte)
  localparam logic [3:0] STS_NOTE_OFF     = 4'h8;
  localparam logic [3:0] STS_NOTE_ON      = 4'h9;
  localparam logic [3:0] STS_CTRL         = 4'hB;

  // Controller number for "all notes off"
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    MSG_IGNORE   = 2'd0,
    MSG_NOTE_ON  = 2'd1,
    MSG_NOTE_OFF = 2'd2,
    MSG_ALL_OFF  = 2'd3
  } msg_class_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_SCAN   = 3'd2,
    S_APPLY  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Map one assembled channel message to the action the scheduler takes.
  // Anything malformed (running-status data byte in the status slot, data
  // bytes with bit7 set) or addressed to another channel is ignored.
  function automatic msg_class_t classify(input logic [7:0] status,
                                          input logic [7:0] d1,
                                          input logic [7:0] d2,
                                          input logic [3:0] channel,
                                          input logic       omni);
    msg_class_t c;
    c = MSG_IGNORE;
    if (status[7] && !d1[7] && !d2[7] && (omni || (status[3:0] == channel))) begin
      case (status[7:4])
        STS_NOTE_ON:  c = (d2[6:0] != 7'd0) ? MSG_NOTE_ON : MSG_NOTE_OFF;
        STS_NOTE_OFF: c = MSG_NOTE_OFF;
        STS_CTRL:     c = (d1[6:0] == CC_ALL_NOTES_OFF) ? MSG_ALL_OFF : MSG_IGNORE;
        default:      c = MSG_IGNORE;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/midi_voice_slot.sv
// One synth voice: gate, note, velocity and a saturating age counter.
// Assign has priority over release and age tick; only gated voices age.
module midi_voice_slot
  import midi_pkg::*;
#(
  parameter int AGE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             assign_en,
  input  logic             release_en,
  input  logic             age_tick,
  input  logic [6:0]       note_in,
  input  logic [6:0]       vel_in,
  output logic             gate,
  output logic [6:0]       note,
  output logic [6:0]       vel,
  output logic [AGE_W-1:0] age
);

  // Age increments until all ones, then sticks there.
  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    return (&a) ? a : a + 1'b1;
  endfunction

  // Voice registers: (re)assign, release, or age the held note
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate <= 1'b0;
      note <= 7'd0;
      vel  <= 7'd0;
      age  <= '0;
    end else if (assign_en) begin
      gate <= 1'b1;
      note <= note_in;
      vel  <= vel_in;
      age  <= '0;
    end else begin
      if (release_en) begin
        gate <= 1'b0;
      end
      if (age_tick && gate) begin
        age <= age_sat_inc(age);
      end
    end
  end

endmodule

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice scheduler: takes assembled MIDI channel messages and
// assigns notes to NUM_VOICES slots (match, then free, then oldest steal).
// Fixed latency: DECODE, NUM_VOICES SCAN cycles, APPLY, DONE.
module midi_voice_alloc
  import midi_pkg::*;
#(
  parameter int         NUM_VOICES = 4,
  parameter logic [3:0] CHANNEL    = 4'd0,
  parameter bit         OMNI       = 1'b0,
  parameter int         AGE_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    msg_valid,
  input  logic [7:0]              msg_status,
  input  logic [7:0]              msg_data1,
  input  logic [7:0]              msg_data2,
  output logic                    busy,
  output logic                    msg_drop,
  output logic                    upd,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_vel
);

  localparam int                IDX_W    = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_t           state;
  state_t           state_nx;
  msg_class_t       cls_q;

  logic [7:0]       status_q;
  logic [7:0]       data1_q;
  logic [7:0]       data2_q;

  logic [IDX_W-1:0] scan_idx;
  logic             match_found;
  logic [IDX_W-1:0] match_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] old_idx;
  logic [AGE_W-1:0] old_age;
  logic [IDX_W-1:0] tgt_idx;

  logic             cur_gate;
  logic [6:0]       cur_note;
  logic [AGE_W-1:0] cur_age;

  logic             apply_on;
  logic             apply_off;
  logic             apply_all;

  logic [NUM_VOICES-1:0] assign_en;
  logic [NUM_VOICES-1:0] release_en;
  logic [NUM_VOICES-1:0] age_tick;
  logic [6:0]            note_a [NUM_VOICES];
  logic [6:0]            vel_a  [NUM_VOICES];
  logic [AGE_W-1:0]      age_a  [NUM_VOICES];

  // Next-state: fixed-length walk through the scan
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (msg_valid) state_nx = S_DECODE;
      S_DECODE: state_nx = S_SCAN;
      S_SCAN:   if (scan_idx == LAST_IDX) state_nx = S_APPLY;
      S_APPLY:  state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Message byte capture on acceptance; payload only, never reset
  always_ff @(posedge clk) begin
    if (state == S_IDLE && msg_valid) begin
      status_q <= msg_status;
      data1_q  <= msg_data1;
      data2_q  <= msg_data2;
    end
  end

  // Voice currently under inspection by the scan
  always_comb begin
    cur_gate = voice_gate[scan_idx];
    cur_note = note_a[scan_idx];
    cur_age  = age_a[scan_idx];
  end

  // FSM, handshake outputs and scan trackers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cls_q       <= MSG_IGNORE;
      busy        <= 1'b0;
      msg_drop    <= 1'b0;
      upd         <= 1'b0;
      voice_trig  <= '0;
      scan_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      old_idx     <= '0;
      old_age     <= '0;
    end else begin
      state      <= state_nx;
      busy       <= (state_nx != S_IDLE);
      msg_drop   <= msg_valid && (state != S_IDLE);
      upd        <= (state == S_APPLY);
      voice_trig <= assign_en;

      if (state == S_DECODE) begin
        cls_q       <= classify(status_q, data1_q, data2_q, CHANNEL, OMNI);
        scan_idx    <= '0;
        match_found <= 1'b0;
        match_idx   <= '0;
        free_found  <= 1'b0;
        free_idx    <= '0;
        old_idx     <= '0;
        old_age     <= '0;
      end

      if (state == S_SCAN) begin
        scan_idx <= scan_idx + 1'b1;
        if (!match_found && cur_gate && (cur_note == data1_q[6:0])) begin
          match_found <= 1'b1;
          match_idx   <= scan_idx;
        end
        if (!free_found && !cur_gate) begin
          free_found <= 1'b1;
          free_idx   <= scan_idx;
        end
        // Strict compare keeps the lowest index on equal ages
        if ((scan_idx == '0) || (cur_age > old_age)) begin
          old_idx <= scan_idx;
          old_age <= cur_age;
        end
      end
    end
  end

  // Note-on target: re-strike a matching voice, else a free one, else steal
  always_comb begin
    tgt_idx = old_idx;
    if (match_found) begin
      tgt_idx = match_idx;
    end else if (free_found) begin
      tgt_idx = free_idx;
    end
  end

  assign apply_on  = (state == S_APPLY) && (cls_q == MSG_NOTE_ON);
  assign apply_off = (state == S_APPLY) && (cls_q == MSG_NOTE_OFF) && match_found;
  assign apply_all = (state == S_APPLY) && (cls_q == MSG_ALL_OFF);

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    assign assign_en[i]  = apply_on && (tgt_idx == IDX_W'(i));
    assign release_en[i] = apply_all || (apply_off && (match_idx == IDX_W'(i)));
    assign age_tick[i]   = apply_on && (tgt_idx != IDX_W'(i));

    midi_voice_slot #(
      .AGE_W (AGE_W)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .assign_en  (assign_en[i]),
      .release_en (release_en[i]),
      .age_tick   (age_tick[i]),
      .note_in    (data1_q[6:0]),
      .vel_in     (data2_q[6:0]),
      .gate       (voice_gate[i]),
      .note       (note_a[i]),
      .vel        (vel_a[i]),
      .age        (age_a[i])
    );

    assign voice_note[7*i +: 7] = note_a[i];
    assign voice_vel[7*i +: 7]  = vel_a[i];
  end

endmodule

// File: doc/midi_voice_alloc.md
Name: midi_voice_alloc

Overview:
Polyphonic voice scheduler downstream of the MIDI byte receiver/assembler. It accepts one assembled 3-byte channel message per handshake and shares NUM_VOICES synth voices between incoming notes. It uses free-voice-first allocation, falls back to oldest-voice stealing, and drives per-voice gate, note and velocity registers for the tone generators.

Parameters:
NUM_VOICES, 4, number of voice slots (2..16)
CHANNEL, 0, 4-bit MIDI channel accepted when OMNI=0
OMNI, 0, 1 = accept all channels
AGE_W, 8, width of per-voice saturating age counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
msg_valid  in  1  1-cycle strobe: assembled message present
msg_status  in  8  status byte
msg_data1  in  8  data byte 1 (note / controller number)
msg_data2  in  8  data byte 2 (velocity / controller value)
busy  out  1  high in every non-IDLE state
msg_drop  out  1  1-cycle pulse: msg_valid seen while busy
upd  out  1  1-cycle pulse: accepted message fully applied
voice_gate  out  NUM_VOICES  per-voice gate
voice_trig  out  NUM_VOICES  1-cycle pulse on voices (re)assigned by note-on
voice_note  out  7*NUM_VOICES  packed note numbers, voice i at [7i+6:7i]
voice_vel  out  7*NUM_VOICES  packed velocities, same packing

Behaviour:
- Reset is asynchronous. All outputs, gates, notes, velocities and ages clear to 0, and the FSM enters IDLE. Reset asserted mid-operation aborts the message with no partial update.
- FSM: IDLE, DECODE, SCAN, APPLY, DONE.
  - IDLE: on msg_valid, latch all 3 bytes and go to DECODE. msg_valid in any other state pulses msg_drop the next cycle and is discarded.
  - DECODE: classify the latched message, then go to SCAN.
    - NOTE_ON: 0x9n with data2 != 0.
    - NOTE_OFF: 0x8n, or 0x9n with data2 == 0.
    - ALL_OFF: 0xBn with data1 == 123.
    - Anything else is IGNORE. This includes the wrong channel, status bit7 = 0, or data bit7 = 1.
  - SCAN: one voice per cycle, index 0..NUM_VOICES-1, tracking:
    - match: lowest index with gate=1 and note=data1
    - free: lowest index with gate=0
    - oldest: highest age; ties go to the lowest index
  - SCAN then goes to APPLY. The scan still runs for IGNORE and ALL_OFF, so latency is fixed.
  - APPLY: registers update at the end of this cycle.
    - NOTE_ON, target priority match > free > oldest. The target gets gate=1, note=data1, vel=data2, age=0. Every other gated voice increments its age, saturating at 2^AGE_W-1.
    - NOTE_OFF: the match voice gets gate=0; note and vel are retained. If there is no match, nothing changes.
    - ALL_OFF: all gates go to 0.
    - IGNORE: no change.
  - DONE: upd=1. voice_trig bit set only for the NOTE_ON target. Go to IDLE.
- Latency: msg_valid accepted in cycle t gives upd in cycle t+NUM_VOICES+3. busy is high in cycles t+1 .. t+NUM_VOICES+3. A new message is accepted from cycle t+NUM_VOICES+4.
- upd pulses for every accepted message, IGNORE included.
- Outputs are registered. voice_* reflect the new state in the DONE cycle.
- Ages of ungated voices hold their value.

Decomposition:
- Shared package midi_pkg:
  - status nibble constants NOTE_OFF=4'h8, NOTE_ON=4'h9, CTRL=4'hB
  - CC_ALL_NOTES_OFF=7'd123
  - message-class enum {IGNORE, NOTE_ON, NOTE_OFF, ALL_OFF}
  - FSM state enum
- Sub-module midi_voice_slot: one voice's gate/note/vel/age registers with assign/release/age-tick controls. Instantiate NUM_VOICES of them in a generate loop. Scan and FSM logic live in the top.

Test Plan:
(All cases use NUM_VOICES=4, CHANNEL=0, OMNI=0.)
- Reset: hold rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately, busy=0.
- Single note: 0x90,0x3C,0x64 at cycle t -> upd at t+7, gate=0001, note0=60, vel0=100, trig=0001.
- Steal: note-ons 60,62,64,65 (vel 100), then 0x90,67,80 -> voice0 (oldest) gets note 67, vel 80, trig=0001, gate=1111.
- Release and retrigger: 0x90,62,0 -> gate bit1=0, trig=0000. Then 0x90,64,50 -> voice2 vel=50, trig=0100, no other voice changes.
- Drop and filter: msg_valid at t+3 while busy -> msg_drop pulse, no state change. 0x91,60,100 -> upd pulses, gates unchanged.
- All off: 0xB0,123,0 -> gate=0000 at upd. Reset asserted during SCAN -> all cleared, no upd.
